// File: rtl/alu_mdu.sv
// Execute-stage ALU with an iterative RV32M multiply/divide unit behind a valid/ready handshake.
// Simple ops finish in one cycle; MUL/DIV share one radix-2 shift-add / shift-subtract datapath.
module alu_mdu #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    input  logic                     kill,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    ALUResult
);

    localparam int SHW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [SHW-1:0]          r_count;
    logic [DATA_WIDTH-1:0]   r_hi;
    logic [DATA_WIDTH-1:0]   r_lo;
    logic [DATA_WIDTH-1:0]   r_opnd;
    logic [2:0]              r_mop;
    logic                    r_negRes;
    logic                    r_negRem;
    logic                    r_divZero;

    logic                    w_accept;
    logic                    w_isMop;
    logic                    w_lastStep;
    logic [SHW-1:0]          w_shamt;
    logic [2:0]              w_mop;
    logic                    w_aSigned;
    logic                    w_bSigned;
    logic                    w_negA;
    logic                    w_negB;
    logic [DATA_WIDTH-1:0]   w_absA;
    logic [DATA_WIDTH-1:0]   w_absB;
    logic [DATA_WIDTH-1:0]   w_aluResult;
    logic [DATA_WIDTH:0]     w_mulSum;
    logic [DATA_WIDTH:0]     w_remShift;
    logic [DATA_WIDTH:0]     w_remDiff;
    logic [DATA_WIDTH-1:0]   w_hiNext;
    logic [DATA_WIDTH-1:0]   w_loNext;
    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [2*DATA_WIDTH-1:0] w_prodFix;
    logic [DATA_WIDTH-1:0]   w_quo;
    logic [DATA_WIDTH-1:0]   w_rem;
    logic [DATA_WIDTH-1:0]   w_mduResult;

    assign w_accept   = in_valid && in_ready && !kill;
    assign w_isMop    = (Operation[4:3] == 2'b10);
    assign w_lastStep = (r_state == S_RUN) && (r_count == SHW'(DATA_WIDTH - 1));
    assign w_shamt    = SrcB[SHW-1:0];
    assign w_mop      = Operation[2:0];

    // Operand signedness: MULH, MULHSU(A only), DIV and REM treat operands as two's complement.
    assign w_aSigned = (w_mop == 3'b001) || (w_mop == 3'b010) || (w_mop == 3'b100) || (w_mop == 3'b110);
    assign w_bSigned = (w_mop == 3'b001) || (w_mop == 3'b100) || (w_mop == 3'b110);
    assign w_negA    = w_aSigned && SrcA[DATA_WIDTH-1];
    assign w_negB    = w_bSigned && SrcB[DATA_WIDTH-1];
    assign w_absA    = w_negA ? -SrcA : SrcA;
    assign w_absB    = w_negB ? -SrcB : SrcB;

    always_comb begin
        w_aluResult = '0;
        case (Operation)
            5'b00000: w_aluResult = SrcA & SrcB;
            5'b00001: w_aluResult = SrcA | SrcB;
            5'b00010: w_aluResult = SrcA + SrcB;
            5'b00011: w_aluResult = SrcA - SrcB;
            5'b00100: w_aluResult = SrcA ^ SrcB;
            5'b00101: w_aluResult = SrcA >> w_shamt;
            5'b00110: w_aluResult = $signed(SrcA) >>> w_shamt;
            5'b00111: w_aluResult = SrcA << w_shamt;
            5'b01000: w_aluResult = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
            5'b01001: w_aluResult = DATA_WIDTH'(SrcA == SrcB);
            5'b01010: w_aluResult = DATA_WIDTH'(SrcA != SrcB);
            5'b01011: w_aluResult = DATA_WIDTH'($signed(SrcA) >= $signed(SrcB));
            5'b01100: w_aluResult = DATA_WIDTH'(SrcA < SrcB);
            5'b01101: w_aluResult = DATA_WIDTH'(SrcA >= SrcB);
            default:  w_aluResult = '0;
        endcase
    end

    // Multiply: {r_hi,r_lo} is the product register with the multiplier in r_lo.
    // Divide: r_hi is the partial remainder, r_lo shifts the dividend out and the quotient in.
    assign w_mulSum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    assign w_remShift = {r_hi, r_lo[DATA_WIDTH-1]};
    assign w_remDiff  = w_remShift - {1'b0, r_opnd};

    always_comb begin
        w_hiNext = '0;
        w_loNext = '0;
        if (r_mop[2]) begin
            if (!w_remDiff[DATA_WIDTH]) begin
                w_hiNext = w_remDiff[DATA_WIDTH-1:0];
                w_loNext = {r_lo[DATA_WIDTH-2:0], 1'b1};
            end else begin
                w_hiNext = w_remShift[DATA_WIDTH-1:0];
                w_loNext = {r_lo[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            w_hiNext = w_mulSum[DATA_WIDTH:1];
            w_loNext = {w_mulSum[0], r_lo[DATA_WIDTH-1:1]};
        end
    end

    assign w_prod    = {w_hiNext, w_loNext};
    assign w_prodFix = r_negRes ? -w_prod : w_prod;
    assign w_quo     = r_divZero ? '1 : (r_negRes ? -w_loNext : w_loNext);
    assign w_rem     = r_negRem ? -w_hiNext : w_hiNext;

    always_comb begin
        w_mduResult = '0;
        case (r_mop)
            3'b000:                 w_mduResult = w_prodFix[DATA_WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_mduResult = w_prodFix[2*DATA_WIDTH-1:DATA_WIDTH];
            3'b100, 3'b101:         w_mduResult = w_quo;
            default:                w_mduResult = w_rem;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (kill) begin
            w_nextState = S_IDLE;
        end else begin
            case (r_state)
                S_RUN:   w_nextState = w_lastStep ? S_DONE : S_RUN;
                default: begin
                    if (in_valid) begin
                        w_nextState = w_isMop ? S_RUN : S_DONE;
                    end else begin
                        w_nextState = S_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        in_ready  = (r_state != S_RUN);
        out_valid = (r_state == S_DONE) && !kill;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_opnd    <= '0;
            r_mop     <= '0;
            r_negRes  <= 1'b0;
            r_negRem  <= 1'b0;
            r_divZero <= 1'b0;
        end else if (w_accept && w_isMop) begin
            r_count   <= '0;
            r_hi      <= '0;
            r_lo      <= w_mop[2] ? w_absA : w_absB;
            r_opnd    <= w_mop[2] ? w_absB : w_absA;
            r_mop     <= w_mop;
            r_negRes  <= w_negA ^ w_negB;
            r_negRem  <= w_negA;
            r_divZero <= (SrcB == '0);
        end else if (r_state == S_RUN) begin
            r_count <= r_count + SHW'(1);
            r_hi    <= w_hiNext;
            r_lo    <= w_loNext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ALUResult <= '0;
        end else if (w_accept && !w_isMop) begin
            ALUResult <= w_aluResult;
        end else if (w_lastStep && !kill) begin
            ALUResult <= w_mduResult;
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: directed vectors with literal expectations plus a cycle-level reference model
// of the handshake, latency and result register that is compared against the DUT every cycle.
module tb_alu_mdu;

    localparam int W = 32;

    localparam logic [4:0] OP_AND    = 5'b00000;
    localparam logic [4:0] OP_OR     = 5'b00001;
    localparam logic [4:0] OP_ADD    = 5'b00010;
    localparam logic [4:0] OP_SUB    = 5'b00011;
    localparam logic [4:0] OP_XOR    = 5'b00100;
    localparam logic [4:0] OP_SRL    = 5'b00101;
    localparam logic [4:0] OP_SRA    = 5'b00110;
    localparam logic [4:0] OP_SLL    = 5'b00111;
    localparam logic [4:0] OP_LT     = 5'b01000;
    localparam logic [4:0] OP_EQ     = 5'b01001;
    localparam logic [4:0] OP_NE     = 5'b01010;
    localparam logic [4:0] OP_GE     = 5'b01011;
    localparam logic [4:0] OP_LTU    = 5'b01100;
    localparam logic [4:0] OP_GEU    = 5'b01101;
    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] SrcA;
    logic [W-1:0] SrcB;
    logic [4:0]   Operation;
    logic         kill;
    logic         out_valid;
    logic [W-1:0] ALUResult;

    int checks = 0;
    int errors = 0;

    int           cyc = 0;
    bit           mPending = 0;
    int           mDue = 0;
    logic [W-1:0] mVal = '0;
    logic [W-1:0] lastRes = '0;
    bit           vld = 0;
    logic [W-1:0] lastExp = '0;

    alu_mdu dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .Operation (Operation),
        .kill      (kill),
        .out_valid (out_valid),
        .ALUResult (ALUResult)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W-1:0] refModel(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint       sa;
        longint       sb;
        longint       ub;
        longint       ps;
        longint       q;
        logic [63:0]  pu;
        logic [W-1:0] r;
        logic [4:0]   sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        sh = b[4:0];
        r  = '0;
        case (op)
            OP_AND:    r = a & b;
            OP_OR:     r = a | b;
            OP_ADD:    r = a + b;
            OP_SUB:    r = a - b;
            OP_XOR:    r = a ^ b;
            OP_SRL:    r = a >> sh;
            OP_SRA:    r = $signed(a) >>> sh;
            OP_SLL:    r = a << sh;
            OP_LT:     r = (sa < sb) ? 1 : 0;
            OP_EQ:     r = (a == b) ? 1 : 0;
            OP_NE:     r = (a != b) ? 1 : 0;
            OP_GE:     r = (sa >= sb) ? 1 : 0;
            OP_LTU:    r = (a < b) ? 1 : 0;
            OP_GEU:    r = (a >= b) ? 1 : 0;
            OP_MUL:    r = a * b;
            OP_MULH:   begin ps = sa * sb; r = ps[63:32]; end
            OP_MULHSU: begin ps = sa * ub; r = ps[63:32]; end
            OP_MULHU:  begin pu = {32'b0, a} * {32'b0, b}; r = pu[63:32]; end
            OP_DIV: begin
                if (b == 0) r = '1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else begin q = sa / sb; r = q[31:0]; end
            end
            OP_REM: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
                else begin q = sa % sb; r = q[31:0]; end
            end
            OP_DIVU:   r = (b == 0) ? '1 : a / b;
            OP_REMU:   r = (b == 0) ? a : a % b;
            default:   r = '0;
        endcase
        return r;
    endfunction

    task automatic checkVal(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances at each rising edge from the handshake rules alone.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            vld = 0;
            if (reset) begin
                mPending = 0;
                lastRes  = '0;
            end else if (kill) begin
                mPending = 0;
            end else if (mPending) begin
                if (mDue == cyc) begin
                    lastRes  = mVal;
                    vld      = 1;
                    mPending = 0;
                end
            end else if (in_valid) begin
                if (Operation[4:3] == 2'b10) begin
                    mPending = 1;
                    mDue     = cyc + W;
                    mVal     = refModel(Operation, SrcA, SrcB);
                end else begin
                    lastRes = refModel(Operation, SrcA, SrcB);
                    vld     = 1;
                end
            end
        end
    end

    // Per-cycle compare of all outputs against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                checkInt("cyc_out_valid", int'(out_valid), 0);
                checkInt("cyc_in_ready", int'(in_ready), 1);
                checkVal("cyc_ALUResult", ALUResult, '0);
            end else begin
                checkInt("cyc_out_valid", int'(out_valid), int'(vld && !kill));
                checkInt("cyc_in_ready", int'(in_ready), int'(!mPending));
                checkVal("cyc_ALUResult", ALUResult, lastRes);
            end
        end
    end

    task automatic applyStimulus(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        in_valid  = 1'b1;
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        @(negedge clk);
        in_valid  = 1'b0;
        SrcA      = ~a;
        SrcB      = $urandom;
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] exp, input int lat);
        int k;
        int lows;
        k    = 1;
        lows = 0;
        #1;
        while (!out_valid && k < 200) begin
            if (!in_ready) lows++;
            @(negedge clk);
            #1;
            k++;
        end
        checkInt({name, "_valid"}, int'(out_valid), 1);
        checkVal(name, ALUResult, exp);
        checkInt({name, "_latency"}, k, lat);
        if (lat > 1) checkInt({name, "_ready_low"}, lows, lat - 1);
    endtask

    task automatic runOp(input string name, input logic [4:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
        applyStimulus(op, a, b);
        checkOutput(name, exp, lat);
        lastExp = exp;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        kill      = 1'b0;
        SrcA      = '0;
        SrcB      = '0;
        Operation = '0;

        checkVal("model_add", refModel(OP_ADD, 32'd5, 32'hFFFF_FFFD), 32'd2);
        checkVal("model_mulhsu", refModel(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        checkVal("model_div", refModel(OP_DIV, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        checkVal("model_rem", refModel(OP_REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

        @(negedge clk);
        #1;
        checkInt("reset_out_valid", int'(out_valid), 0);
        checkInt("reset_in_ready", int'(in_ready), 1);
        checkVal("reset_result", ALUResult, '0);
        @(negedge clk);
        reset = 1'b0;

        @(negedge clk);
        in_valid  = 1'b1;
        Operation = OP_ADD;
        SrcA      = 32'd5;
        SrcB      = 32'hFFFF_FFFD;
        @(negedge clk);
        Operation = OP_SUB;
        SrcA      = 32'd5;
        SrcB      = 32'd7;
        #1;
        checkInt("b2b_valid0", int'(out_valid), 1);
        checkVal("b2b_add", ALUResult, 32'd2);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checkInt("b2b_valid1", int'(out_valid), 1);
        checkVal("b2b_sub", ALUResult, 32'hFFFF_FFFE);

        runOp("lt",     OP_LT,  32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        runOp("ltu",    OP_LTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        runOp("geu",    OP_GEU, 32'd0, 32'd0, 32'd1, 1);
        runOp("sra",    OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1);
        runOp("srl",    OP_SRL, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1);
        runOp("sll",    OP_SLL, 32'h0000_0003, 32'd31, 32'h8000_0000, 1);
        runOp("xor",    OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1);
        runOp("ge",     OP_GE,  32'h8000_0000, 32'd1, 32'd0, 1);
        runOp("ne",     OP_NE,  32'd9, 32'd9, 32'd0, 1);
        runOp("unused", 5'b11111, 32'd9, 32'd9, 32'd0, 1);

        runOp("mul",    OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33);
        runOp("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        runOp("mulh",   OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 33);
        runOp("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        runOp("mul_big", OP_MUL,   32'h0001_2345, 32'h0000_1000, 32'h1234_5000, 33);

        runOp("div_neg",  OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        runOp("rem_neg",  OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        runOp("divu_z",   OP_DIVU, 32'd10, 32'd0, 32'hFFFF_FFFF, 33);
        runOp("remu_z",   OP_REMU, 32'd10, 32'd0, 32'd10, 33);
        runOp("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        runOp("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
        runOp("div_z",    OP_DIV,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 33);
        runOp("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 33);

        applyStimulus(OP_DIV, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        kill = 1'b1;
        #1;
        checkInt("kill_valid", int'(out_valid), 0);
        @(negedge clk);
        kill = 1'b0;
        #1;
        checkInt("kill_ready", int'(in_ready), 1);
        checkVal("kill_hold", ALUResult, lastExp);

        @(negedge clk);
        kill      = 1'b1;
        in_valid  = 1'b1;
        Operation = OP_ADD;
        SrcA      = 32'd1;
        SrcB      = 32'd1;
        @(negedge clk);
        kill     = 1'b0;
        in_valid = 1'b0;
        #1;
        checkInt("killacc_valid", int'(out_valid), 0);
        checkInt("killacc_ready", int'(in_ready), 1);
        checkVal("killacc_hold", ALUResult, lastExp);
        repeat (40) @(negedge clk);

        applyStimulus(OP_MUL, 32'd7, 32'd9);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        checkInt("rstmid_out_valid", int'(out_valid), 0);
        checkInt("rstmid_in_ready", int'(in_ready), 1);
        checkVal("rstmid_result", ALUResult, '0);
        @(negedge clk);
        reset = 1'b0;
        runOp("mul_after_reset", OP_MUL, 32'd3, 32'd4, 32'd12, 33);
        runOp("and_after", OP_AND, 32'hFFFF_0F0F, 32'h0F0F_FFFF, 32'h0F0F_0F0F, 1);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised, sequential successor to the single-cycle execute ALU. It adds the RV32M multiply/divide operations, signed and unsigned compares, and a valid/ready handshake with a registered result. Simple ALU operations complete in one cycle. Multiply and divide run on a shared radix-2 iterative datapath with fixed latency. The block sits in the execute stage, and the pipeline stalls while `in_ready` is low.

## Interface
- `DATA_WIDTH`, 32: operand and result width; ≥ 8, power of two.
- `OPCODE_LENGTH`, 5: width of `Operation`; fixed at 5 for this encoding.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operands and `Operation` are valid this cycle.
- `in_ready` output 1: block can accept; a transfer occurs when `in_valid && in_ready` at the edge.
- `SrcA` input DATA_WIDTH: operand A.
- `SrcB` input DATA_WIDTH: operand B.
- `Operation` input OPCODE_LENGTH: operation select.
- `kill` input 1: abort any in-flight operation (pipeline flush).
- `out_valid` output 1: one-cycle pulse; `ALUResult` is valid.
- `ALUResult` output DATA_WIDTH: registered result; holds its value until the next completion.

## Operation
- **Single-cycle opcodes:**
  - 00000 AND, 00001 OR, 00010 ADD, 00011 SUB, 00100 XOR.
  - 00101 SRL, 00110 SRA, 00111 SLL; shift amount is `SrcB[log2(DATA_WIDTH)-1:0]`.
  - 01000 LT (signed), 01001 EQ, 01010 NE, 01011 GE (signed), 01100 LTU, 01101 GEU.
  - Compare ops return 1 or 0, zero-extended.
  - Any unlisted opcode returns 0 with single-cycle latency.
- **Iterative opcodes:**
  - 10000 MUL: low half of the product.
  - 10001 MULH (s×s), 10010 MULHSU (s×u), 10011 MULHU (u×u): high half of the product.
  - 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
  - Signed ops take operand magnitudes at accept and apply sign correction at DONE.
- **Division special cases (RISC-V semantics):**
  - Divide by zero: quotient is all ones; remainder equals the dividend.
  - Signed overflow (most negative value / −1): quotient equals the dividend; remainder is 0.
  - Latency is unchanged for special cases.
- **FSM states:**
  - IDLE: `in_ready`=1. On accept of a single-cycle op, compute and register `ALUResult`, then go to DONE. On accept of an M op, latch operands, clear the iteration counter, and go to RUN.
  - RUN: `in_ready`=0. One shift-add or shift-subtract step per cycle. The counter increments from 0 to DATA_WIDTH−1; at count DATA_WIDTH−1, register the corrected result and go to DONE.
  - DONE: `out_valid`=1 and `in_ready`=1. An accept in DONE behaves exactly like an accept in IDLE, giving back-to-back issue. With no accept, go to IDLE.
- **Kill:**
  - `kill` forces IDLE at the next edge from any state.
  - `out_valid` is 0 in the cycle `kill` is high, and `ALUResult` keeps its prior value.
  - `kill` has priority over a simultaneous `in_valid`; nothing is accepted.
- Operand changes while in RUN are ignored, because operands are latched at accept.
- Arithmetic wraps modulo 2^DATA_WIDTH. Iterative datapath registers are 2·DATA_WIDTH wide for multiply and DATA_WIDTH+1 wide for the partial remainder.

## Timing
- **Reset values:** state = IDLE, `ALUResult` = 0, `out_valid` = 0, `in_ready` = 1, counter = 0. Reset asserted mid-RUN aborts immediately with the same values.
- **Single-cycle ops:** accepted at edge N; `out_valid` is high in the cycle after edge N. Throughput is 1 per cycle.
- **M ops:** accepted at edge N; `out_valid` is high in the cycle after edge N+DATA_WIDTH, a latency of DATA_WIDTH+1 (33 at default). `in_ready` is low for DATA_WIDTH cycles.
- `in_ready` is a decode of registered state only; it has no combinational path from `in_valid`.
- `out_valid` has no backpressure, so the consumer must take the result in the pulse cycle.

## Test plan
- **Single-cycle pipelining:** ADD `SrcA`=5, `SrcB`=0xFFFFFFFD issued back-to-back with SUB 5, 7 → `ALUResult`=2 then 0xFFFFFFFE, with `out_valid` high in two consecutive cycles.
- **Compares:** LT 0xFFFFFFFF, 1 → 1. LTU with the same operands → 0. GEU 0, 0 → 1. SRA 0x80000000 by 4 → 0xF8000000.
- **Multiply, 0xFFFFFFFF × 0xFFFFFFFF:**
  - MUL → 1; MULHU → 0xFFFFFFFE; MULH → 0; MULHSU → 0xFFFFFFFF.
  - Each completes exactly 33 cycles after accept, with `in_ready` low for 32 cycles.
- **Divide:**
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
  - DIVU 10/0 → 0xFFFFFFFF; REMU 10/0 → 10.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- **Kill:** assert `kill` 10 cycles into a DIV → no `out_valid`, `in_ready`=1 next cycle, `ALUResult` unchanged. Then `kill` and `in_valid` in the same cycle → no accept.
- **Reset mid-op:** assert `reset` mid-MUL → outputs immediately return to their reset values. A subsequent MUL 3×4 → 12 with full latency.
